// File: rtl/ps2_scan_decoder.sv
// Purpose: PS/2 keyboard receiver and scan-code-set-2 decoder (E0 extended, F0 break, E1 pause skip).
// Latency: make/brakee fire 2 clk after the stop-bit sample event; frameError fires 1 clk after it.
// Backpressure: none. The PS/2 device cannot be stalled, so every output is a fire-and-forget pulse.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous to clk)
//   ps2_data   raw PS/2 data (asynchronous to clk)
//   keyCode    {extended, scan byte}; holds its value until the next make/brakee
//   make       one-clk pulse, key pressed
//   brakee     one-clk pulse, key released
//   frameError one-clk pulse, parity/stop error or inter-bit timeout
module ps2_scan_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int PAUSE_SKIP     = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [8:0] keyCode,
   output logic       make,
   output logic       brakee,
   output logic       frameError
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(PAUSE_SKIP + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} scan_state_t;

   // ---------------- input conditioning ----------------
   // Synchronizers reset to 1 (idle bus level) so reset release cannot fake an edge.
   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          filt_clk_q, filt_prev_q;
   logic [FW-1:0] filt_cnt_q;
   logic          sample_evt;
   logic          dat_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         dat_sync_q  <= 2'b11;
         filt_clk_q  <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         dat_sync_q  <= {dat_sync_q[0], ps2_data};
         filt_prev_q <= filt_clk_q;
         // Count consecutive samples that disagree with the filtered level;
         // any agreeing sample restarts the count.
         if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
               filt_clk_q <= clk_sync_q[1];
               filt_cnt_q <= '0;
            end else begin
               filt_cnt_q <= filt_cnt_q + FW'(1);
            end
         end else begin
            filt_cnt_q <= '0;
         end
      end
   end

   assign sample_evt = filt_prev_q & ~filt_clk_q;
   assign dat_s      = dat_sync_q[1];

   // ---------------- frame receiver ----------------
   rx_state_t     rx_state_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [TW-1:0] timer_q;
   logic          byte_vld_q;
   logic          ferr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         timer_q    <= '0;
         byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
         if (sample_evt) begin
            timer_q <= '0;
            case (rx_state_q)
               RX_IDLE: begin
                  // A high bit while idle is line noise or a stray edge; ignore it.
                  if (!dat_s) begin
                     rx_state_q <= RX_DATA;
                     bitcnt_q   <= '0;
                  end
               end
               RX_DATA: begin
                  shift_q  <= {dat_s, shift_q[7:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) rx_state_q <= RX_PARITY;
               end
               RX_PARITY: begin
                  par_q      <= dat_s;
                  rx_state_q <= RX_STOP;
               end
               RX_STOP: begin
                  // Odd parity: data plus parity bit must hold an odd number of ones.
                  if (dat_s && (^{shift_q, par_q})) byte_vld_q <= 1'b1;
                  else                              ferr_q     <= 1'b1;
                  rx_state_q <= RX_IDLE;
               end
               default: rx_state_q <= RX_IDLE;
            endcase
         end else if (rx_state_q != RX_IDLE) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               rx_state_q <= RX_IDLE;
               ferr_q     <= 1'b1;
               timer_q    <= '0;
            end else begin
               timer_q <= timer_q + TW'(1);
            end
         end
      end
   end

   // ---------------- scan-code decoder ----------------
   scan_state_t   scan_q;
   logic [SW-1:0] skip_q;
   logic [8:0]    key_q;
   logic          make_q, brk_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_q <= S_BASE;
         skip_q <= '0;
         key_q  <= '0;
         make_q <= 1'b0;
         brk_q  <= 1'b0;
      end else begin
         make_q <= 1'b0;
         brk_q  <= 1'b0;
         if (ferr_q) begin
            // A broken frame invalidates any prefix collected so far.
            scan_q <= S_BASE;
            skip_q <= '0;
         end else if (byte_vld_q) begin
            case (scan_q)
               S_BASE: begin
                  if (shift_q == 8'hE0)      scan_q <= S_EXT;
                  else if (shift_q == 8'hF0) scan_q <= S_BRK;
                  else if (shift_q == 8'hE1) begin
                     scan_q <= S_PAUSE;
                     skip_q <= SW'(PAUSE_SKIP);
                  end else if (shift_q == 8'hAA || shift_q == 8'hFA || shift_q == 8'hFC ||
                               shift_q == 8'hEE || shift_q == 8'hFE) begin
                     // Keyboard status/ack responses, not key events.
                     scan_q <= S_BASE;
                  end else begin
                     key_q  <= {1'b0, shift_q};
                     make_q <= 1'b1;
                  end
               end
               S_EXT: begin
                  if (shift_q == 8'hF0)      scan_q <= S_EXT_BRK;
                  else if (shift_q == 8'hE0) scan_q <= S_EXT;
                  else begin
                     key_q  <= {1'b1, shift_q};
                     make_q <= 1'b1;
                     scan_q <= S_BASE;
                  end
               end
               S_BRK: begin
                  key_q  <= {1'b0, shift_q};
                  brk_q  <= 1'b1;
                  scan_q <= S_BASE;
               end
               S_EXT_BRK: begin
                  key_q  <= {1'b1, shift_q};
                  brk_q  <= 1'b1;
                  scan_q <= S_BASE;
               end
               S_PAUSE: begin
                  skip_q <= skip_q - SW'(1);
                  if (skip_q <= SW'(1)) scan_q <= S_BASE;
               end
               default: scan_q <= S_BASE;
            endcase
         end
      end
   end

   assign keyCode    = key_q;
   assign make       = make_q;
   assign brakee     = brk_q;
   assign frameError = ferr_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

   localparam int FILTER_LEN = 2;
   localparam int TIMEOUT    = 200;
   localparam int BIT_HALF   = 20;
   // ps2_clk fall to make: 2 synchronizer flops + filter + 2 clk event-to-pulse.
   localparam int EXP_LAT    = 2 + FILTER_LEN + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [8:0] keyCode;
   logic       make;
   logic       brakee;
   logic       frameError;

   always #5 clk = ~clk;

   ps2_scan_decoder #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT),
      .PAUSE_SKIP    (7)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyCode   (keyCode),
      .make      (make),
      .brakee    (brakee),
      .frameError(frameError)
   );

   // kind: 0 = make, 1 = brakee, 2 = frameError
   typedef struct packed {
      logic [1:0] kind;
      logic [8:0] code;
      logic       chk_lat;
   } exp_t;

   exp_t       sbq[$];
   int         nvec = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         last_fall_cyc = 0;
   logic [8:0] kc_prev = 9'h0;
   logic [1:0] mon_k;
   exp_t       mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every pulse is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (!reset) begin
         if (keyCode !== kc_prev) begin
            nvec++;
            assert (make || brakee) else begin
               nerr++;
               $error("FAIL keycode_change_without_pulse obs=%h prev=%h exp=make|brakee", keyCode, kc_prev);
            end
         end
         if (make || brakee || frameError) begin
            nvec++;
            assert ($onehot({make, brakee, frameError})) else begin
               nerr++;
               $error("FAIL pulse_onehot obs=%b exp=one-hot", {make, brakee, frameError});
            end
            mon_k = make ? 2'd0 : (brakee ? 2'd1 : 2'd2);
            nvec++;
            if (sbq.size() == 0) begin
               nerr++;
               $error("FAIL unexpected_pulse obs kind=%0d code=%h exp=none", mon_k, keyCode);
            end else begin
               mon_e = sbq.pop_front();
               assert ({mon_k, (mon_k == 2'd2) ? 9'h0 : keyCode} === {mon_e.kind, mon_e.code}) else begin
                  nerr++;
                  $error("FAIL pulse_value obs kind=%0d code=%h exp kind=%0d code=%h",
                         mon_k, keyCode, mon_e.kind, mon_e.code);
               end
               if (mon_e.chk_lat) begin
                  nvec++;
                  assert (cyc - last_fall_cyc == EXP_LAT) else begin
                     nerr++;
                     $error("FAIL latency obs=%0d exp=%0d", cyc - last_fall_cyc, EXP_LAT);
                  end
               end
            end
         end
      end
      kc_prev = keyCode;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (BIT_HALF) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (BIT_HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11);
   endtask

   task automatic push(input logic [1:0] kind, input logic [8:0] code, input logic lat);
      exp_t e;
      e.kind    = kind;
      e.code    = code;
      e.chk_lat = lat;
      sbq.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      idle(50);
      nvec++;
      assert (sbq.size() == 0) else begin
         nerr++;
         $error("FAIL %s_drain obs pending=%0d exp=0", tag, sbq.size());
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      idle(5);
      nvec++;
      assert ({keyCode, make, brakee, frameError} === 12'h0) else begin
         nerr++;
         $error("FAIL reset_state obs=%h exp=000", {keyCode, make, brakee, frameError});
      end
      reset = 1'b0;
      idle(20);

      // 1: plain make with latency check
      push(2'd0, 9'h01C, 1'b1);
      send_byte(8'h1C);
      drain("t1");
      nvec++;
      assert (keyCode === 9'h01C) else begin
         nerr++;
         $error("FAIL t1_hold obs=%h exp=01C", keyCode);
      end

      // 2: break
      push(2'd1, 9'h01C, 1'b0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      drain("t2");

      // 3: extended make and extended break
      push(2'd0, 9'h175, 1'b0);
      send_byte(8'hE0);
      send_byte(8'h75);
      push(2'd1, 9'h175, 1'b0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      drain("t3");

      // 4: parity error then a good byte
      push(2'd2, 9'h0, 1'b0);
      send_frame(8'h29, 1'b1, 11);
      push(2'd0, 9'h01C, 1'b0);
      send_byte(8'h1C);
      drain("t4");

      // 5: E0 then truncated frame -> timeout drops prefix
      send_byte(8'hE0);
      push(2'd2, 9'h0, 1'b0);
      send_frame(8'h6B, 1'b0, 4);
      drain("t5_timeout");
      push(2'd0, 9'h074, 1'b0);
      send_byte(8'h74);
      drain("t5");

      // 6: Pause sequence, keyboard status byte, then a key
      send_byte(8'hE1);
      send_byte(8'h14);
      send_byte(8'h77);
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h77);
      send_byte(8'hAA);
      push(2'd0, 9'h01C, 1'b0);
      send_byte(8'h1C);
      drain("t6");

      // Reset mid-frame: prefix and partial byte are lost
      send_byte(8'hE0);
      send_frame(8'h1C, 1'b0, 5);
      reset = 1'b1;
      idle(3);
      nvec++;
      assert ({keyCode, make, brakee, frameError} === 12'h0) else begin
         nerr++;
         $error("FAIL midframe_reset obs=%h exp=000", {keyCode, make, brakee, frameError});
      end
      reset = 1'b0;
      idle(300);
      push(2'd0, 9'h074, 1'b0);
      send_byte(8'h74);
      drain("reset_recover");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
